// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the decode/dispatch queue.
// Holds the op-class enum, ALU control codes, RV32 opcodes and the decoded
// record that travels through the queue.
package decode_pkg;

  // Width of the PC and immediate fields carried in a decoded record.
  localparam int DEC_XLEN = 32;

  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_ILLEGAL = 3'd7
  } op_cls_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    op_cls_e               cls;
    logic [3:0]            aluctl;
    logic [2:0]            funct3;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [DEC_XLEN-1:0]   imm;
    logic [DEC_XLEN-1:0]   pc;
    logic                  illegal;
  } dec_rec_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational RV32 decode of one raw instruction into a
// dec_rec_t. Optional feature macro: RV32I_FULL_ALU_EN (adds XOR, SLTU and
// the shifts; without it those funct3 values decode as ILLEGAL).
import decode_pkg::*;

module instr_decoder (
  input  logic [31:0]         instr,
  input  logic [DEC_XLEN-1:0] pc,
  output dec_rec_t            rec
);

  logic [DEC_XLEN-1:0] imm_i;
  logic [DEC_XLEN-1:0] imm_s;
  logic [DEC_XLEN-1:0] imm_b;
  logic [DEC_XLEN-1:0] imm_j;
  logic [2:0]          funct3;
  logic                is_imm;

  assign funct3 = instr[14:12];
  // OP-IMM and OP differ only in opcode bit 5.
  assign is_imm = ~instr[5];

  assign imm_i = {{(DEC_XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(DEC_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(DEC_XLEN-13){instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(DEC_XLEN-21){instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  logic bad;

  // Decode opcode and funct3 into the record; any unknown encoding collapses
  // to a zeroed ILLEGAL record that keeps only the PC.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    rec        = '0;
    bad        = 1'b0;
    rec.pc     = pc;
    rec.funct3 = funct3;
    rec.rd     = instr[11:7];
    rec.rs1    = instr[19:15];
    rec.rs2    = instr[24:20];
    case (instr[6:0])
      OPC_LOAD: begin
        rec.cls    = CLS_LOAD;
        rec.aluctl = ALU_ADD;
        rec.imm    = imm_i;
      end
      OPC_STORE: begin
        rec.cls    = CLS_STORE;
        rec.aluctl = ALU_ADD;
        rec.imm    = imm_s;
        rec.rd     = '0;
      end
      OPC_BRANCH: begin
        rec.cls    = CLS_BRANCH;
        rec.aluctl = ALU_SUB;
        rec.imm    = imm_b;
        rec.rd     = '0;
      end
      OPC_JAL: begin
        rec.cls    = CLS_JAL;
        rec.aluctl = ALU_ADD;
        rec.imm    = imm_j;
        rec.rs1    = '0;
        rec.rs2    = '0;
      end
      OPC_OP, OPC_OP_IMM: begin
        rec.cls = CLS_ALU;
        rec.imm = is_imm ? imm_i : '0;
        case (funct3)
          // ADDI has no SUB form, so instr[30] only matters for R-type.
          3'b000: rec.aluctl = (!is_imm && instr[30]) ? ALU_SUB : ALU_ADD;
          3'b010: rec.aluctl = ALU_SLT;
          3'b110: rec.aluctl = ALU_OR;
          3'b111: rec.aluctl = ALU_AND;
`ifdef RV32I_FULL_ALU_EN
          3'b001: begin
            rec.aluctl = ALU_SLL;
            rec.imm    = is_imm ? {{(DEC_XLEN-5){1'b0}}, instr[24:20]} : '0;
          end
          3'b011: rec.aluctl = ALU_SLTU;
          3'b100: rec.aluctl = ALU_XOR;
          3'b101: begin
            rec.aluctl = instr[30] ? ALU_SRA : ALU_SRL;
            rec.imm    = is_imm ? {{(DEC_XLEN-5){1'b0}}, instr[24:20]} : '0;
          end
`endif
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      rec         = '0;
      rec.pc      = pc;
      rec.cls     = CLS_ILLEGAL;
      rec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_dispatch_queue.sv
// decode_dispatch_queue: decodes fetched RV32 instructions and buffers the
// decoded records in a DEPTH-entry FIFO ahead of reservation-station
// dispatch. Optional feature macro RV32I_FULL_ALU_EN lives in instr_decoder.
import decode_pkg::*;

module decode_dispatch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = DEC_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_cls,
  output logic [3:0]      out_aluctl,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);

  dec_rec_t        mem [DEPTH];
  dec_rec_t        dec_rec;
  dec_rec_t        head;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW:0]     count;
  logic            push;
  logic            pop;

  instr_decoder u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .rec   (dec_rec)
  );

  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pointer and occupancy tracking; flush empties the queue and wins over
  // any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Record storage written on every accepted push.
  // NOTE: the storage array has no reset; stale entries are never visible
  // because the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec_rec;
  end

  assign head = out_valid ? mem[rptr] : '0;

  assign out_cls     = head.cls;
  assign out_aluctl  = head.aluctl;
  assign out_funct3  = head.funct3;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_imm     = head.imm;
  assign out_pc      = head.pc;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// tb_decode_dispatch_queue: directed and randomized stimulus against a
// queue-based behavioural model with an arithmetic reference decoder.
module tb_decode_dispatch_queue;

  localparam int DEPTH = 4;
`ifdef RV32I_FULL_ALU_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_cls;
  logic [3:0]  out_aluctl;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic        out_illegal;

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  typedef struct packed {
    logic [2:0]  cls;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  exp_t        ce;
  logic [31:0] cpc;

  decode_dispatch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_cls     (out_cls),
    .out_aluctl  (out_aluctl),
    .out_funct3  (out_funct3),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm     (out_imm),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode built from the ISA rules with plain arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t       e;
    int         s;
    int         hi;
    logic [3:0] rtab [8];
    logic [2:0] f3;
    bit         imm_form;
    bit         bad;
    s        = ins;
    f3       = ins[14:12];
    bad      = 1'b0;
    e        = '0;
    e.f3     = f3;
    e.rd     = ins[11:7];
    e.rs1    = ins[19:15];
    e.rs2    = ins[24:20];
    rtab     = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    imm_form = (ins[6:0] == 7'h13);
    case (ins[6:0])
      7'h03: begin e.cls = 3'd2; e.imm = s >>> 20; end
      7'h23: begin
        hi = s >>> 25;
        e.cls = 3'd3; e.rd = 5'd0; e.imm = hi * 32 + ins[11:7];
      end
      7'h63: begin
        hi = s >>> 31;
        e.cls = 3'd4; e.alu = 4'd1; e.rd = 5'd0;
        e.imm = hi * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
      end
      7'h6F: begin
        hi = s >>> 31;
        e.cls = 3'd5; e.rs1 = 5'd0; e.rs2 = 5'd0;
        e.imm = hi * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
      end
      7'h33, 7'h13: begin
        e.cls = 3'd1;
        e.alu = rtab[f3];
        if (f3 == 3'd0 && !imm_form && ins[30]) e.alu = 4'd1;
        if (f3 == 3'd5 && ins[30]) e.alu = 4'd9;
        if (imm_form) e.imm = s >>> 20;
        if (imm_form && (f3 == 3'd1 || f3 == 3'd5)) e.imm = ins[24:20];
        if (!FULL && (f3 == 3'd1 || f3 == 3'd3 || f3 == 3'd4 || f3 == 3'd5)) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      e     = '0;
      e.cls = 3'd7;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [7];
    logic [31:0] r;
    r   = $urandom();
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
    ops[6] = r[6:0];
    return {r[31:7], ops[$urandom_range(0, 6)]};
  endfunction

  // Behavioural queue: mirrors accepted pushes/pops at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = (q.size() != 0) && out_ready;
      do_push = in_valid && (q.size() < DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{in_instr, in_pc});
    end
  end

  // Every falling edge: DUT head and handshake must match the model.
  always @(negedge clk) begin
    if (checking && rst_n) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
      if (q.size() != 0) begin
        ce  = ref_decode(q[0].instr);
        cpc = q[0].pc;
      end else begin
        ce  = '0;
        cpc = '0;
      end
      check("cls", {29'd0, out_cls}, {29'd0, ce.cls});
      check("aluctl", {28'd0, out_aluctl}, {28'd0, ce.alu});
      check("funct3", {29'd0, out_funct3}, {29'd0, ce.f3});
      check("rd", {27'd0, out_rd}, {27'd0, ce.rd});
      check("rs1", {27'd0, out_rs1}, {27'd0, ce.rs1});
      check("rs2", {27'd0, out_rs2}, {27'd0, ce.rs2});
      check("imm", out_imm, ce.imm);
      check("pc", out_pc, cpc);
      check("illegal", {31'd0, out_illegal}, {31'd0, ce.ill});
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = p;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;

    // lw x6,8(x1)
    step(1'b1, 32'h0080A303, 32'h100, 1'b0, 1'b0);
    check("lw_cls", {29'd0, out_cls}, 32'd2);
    check("lw_aluctl", {28'd0, out_aluctl}, 32'd0);
    check("lw_rd", {27'd0, out_rd}, 32'd6);
    check("lw_rs1", {27'd0, out_rs1}, 32'd1);
    check("lw_imm", out_imm, 32'd8);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // add then sub, consumed in order
    step(1'b1, 32'h002081B3, 32'h104, 1'b1, 1'b0);
    check("add_aluctl", {28'd0, out_aluctl}, 32'd0);
    check("add_rd", {27'd0, out_rd}, 32'd3);
    step(1'b1, 32'h40208233, 32'h108, 1'b1, 1'b0);
    check("sub_aluctl", {28'd0, out_aluctl}, 32'd1);
    check("sub_rd", {27'd0, out_rd}, 32'd4);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // fill to DEPTH, hold a fifth, then free one slot
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h002081B3, 32'h200 + 4 * i, 1'b0, 1'b0);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 32'h40208233, 32'h210, 1'b0, 1'b0);
    check("held_ready", {31'd0, in_ready}, 32'd0);
    check("held_head_pc", out_pc, 32'h200);
    step(1'b1, 32'h40208233, 32'h210, 1'b1, 1'b0);
    check("slot_free_ready", {31'd0, in_ready}, 32'd1);
    step(1'b1, 32'h40208233, 32'h210, 1'b0, 1'b0);
    check("refill_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("empty_valid", {31'd0, out_valid}, 32'd0);

    // streaming with wrap, then flush against a push
    for (int i = 0; i < 10; i++) step(1'b1, rand_instr(), 32'h300 + 4 * i, 1'b1, 1'b0);
    step(1'b1, 32'h002081B3, 32'h400, 1'b0, 1'b1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);

    // sll x5,x1,x2 (build dependent), then a reserved opcode
    step(1'b1, 32'h002092B3, 32'h500, 1'b0, 1'b0);
    check("sll_cls", {29'd0, out_cls}, FULL ? 32'd1 : 32'd7);
    check("sll_aluctl", {28'd0, out_aluctl}, FULL ? 32'd7 : 32'd0);
    check("sll_illegal", {31'd0, out_illegal}, FULL ? 32'd0 : 32'd1);
    step(1'b1, 32'h0000007F, 32'h504, 1'b1, 1'b0);
    check("op7f_cls", {29'd0, out_cls}, 32'd7);
    check("op7f_illegal", {31'd0, out_illegal}, 32'd1);
    check("op7f_pc", out_pc, 32'h504);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // reset asserted mid-stream while pushing
    step(1'b1, 32'h0080A303, 32'h600, 1'b0, 1'b0);
    step(1'b1, 32'h0080A303, 32'h604, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_cls", {29'd0, out_cls}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end

    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
